// File: rtl/fir_pkg.sv
// Shared constants, controller state type and latency helper for the FIR back-end.
package fir_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int Q15_MAX    = 32767;
   localparam int Q15_MIN    = -32768;

   // The 16-tap symmetric filter folds into 8 pre-added pairs ahead of the product tree.
   localparam int FIR_FOLDED_TAPS = 8;

   function automatic int fir_latency(input int n);
      return 7 + $clog2(n / 2);
   endfunction

   typedef enum logic {
      WARMUP = 1'b0,
      RUN    = 1'b1
   } fir_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; the head register keeps the
// last displayed sample on out_data once the FIFO runs empty.
module fir_sync_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_flush,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [DATA_WIDTH-1:0]   i_data,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_fill
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_do_push;
   logic                  w_do_pop;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !i_flush && !w_empty;
   assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   // Tracks the head every non-empty cycle so an emptied FIFO keeps showing it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_hold <= '0;
      else if (!w_empty) r_hold <= w_head;
   end

   assign o_data  = w_empty ? r_hold : w_head;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_fill  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fir_decim_buffer.sv
// Drops FIR pipeline-fill samples, keeps every DECIM-th valid sample and queues it for a
// valid/ready consumer. Optional saturation-rail counter under FIR_DECIM_SATCNT_EN.
module fir_decim_buffer
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH  = fir_pkg::DATA_WIDTH,
   parameter int FIR_LATENCY = fir_latency(FIR_FOLDED_TAPS),
   parameter int DECIM       = 4,
   parameter int DEPTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          flush,
   input  logic signed [DATA_WIDTH-1:0]  y_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic [$clog2(DEPTH):0]        fill_level,
   output logic                          warm,
   output logic                          overflow
`ifdef FIR_DECIM_SATCNT_EN
   ,output logic [15:0]                  sat_count
`endif
);

   localparam int WCW = $clog2(FIR_LATENCY + 1);
   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

   fir_state_e            r_state;
   fir_state_e            w_state_nx;
   logic [WCW-1:0]        r_warm_cnt;
   logic [DCW-1:0]        r_decim_cnt;
   logic                  r_overflow;
   logic                  w_keep;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_fifo_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= WARMUP;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_keep     = 1'b0;
      case (r_state)
         WARMUP: begin
            if (enable && (r_warm_cnt == WCW'(FIR_LATENCY - 1))) w_state_nx = RUN;
         end
         RUN: begin
            w_keep = enable && (r_decim_cnt == '0);
         end
      endcase
      if (flush) begin
         w_state_nx = WARMUP;
         w_keep     = 1'b0;
      end
   end

   // Counters move only on enabled cycles; warm_cnt parks at 0 once RUN is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_warm_cnt  <= '0;
         r_decim_cnt <= '0;
      end else if (flush) begin
         r_warm_cnt  <= '0;
         r_decim_cnt <= '0;
      end else if (enable) begin
         if (r_state == WARMUP) begin
            r_warm_cnt  <= (w_state_nx == RUN) ? '0 : r_warm_cnt + 1'b1;
            r_decim_cnt <= '0;
         end else if (r_decim_cnt == DCW'(DECIM - 1)) begin
            r_decim_cnt <= '0;
         end else begin
            r_decim_cnt <= r_decim_cnt + 1'b1;
         end
      end
   end

   assign w_pop  = !w_empty && out_ready && !flush;
   assign w_push = w_keep && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           r_overflow <= 1'b0;
      else if (flush)                       r_overflow <= 1'b0;
      else if (w_keep && w_full && !w_pop)  r_overflow <= 1'b1;
   end

   fir_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (y_in),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_fill  (fill_level)
   );

   assign out_valid = !w_empty;
   assign out_data  = w_fifo_data;
   assign warm      = (r_state == RUN);
   assign overflow  = r_overflow;

`ifdef FIR_DECIM_SATCNT_EN
   logic [15:0] r_sat_cnt;
   logic        w_is_rail;

   assign w_is_rail = (int'(y_in) == Q15_MAX) || (int'(y_in) == Q15_MIN);

   // Counted at the keep decision, so rail samples lost to overflow still register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_sat_cnt <= '0;
      else if (flush)  r_sat_cnt <= '0;
      else if (w_keep && w_is_rail && (r_sat_cnt != 16'hFFFF))
                       r_sat_cnt <= r_sat_cnt + 1'b1;
   end

   assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Self-checking bench for fir_decim_buffer: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a queue-based model.
module tb_fir_decim_buffer;

   localparam int L     = 9;
   localparam int DECIM = 4;
   localparam int DEPTH = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               flush = 1'b0;
   logic signed [15:0] y_in = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [15:0] out_data;
   logic [3:0]         fill_level;
   logic               warm;
   logic               overflow;
`ifdef FIR_DECIM_SATCNT_EN
   logic [15:0]        sat_count;
`endif

   fir_decim_buffer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .flush      (flush),
      .y_in       (y_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fill_level (fill_level),
      .warm       (warm),
      .overflow   (overflow)
`ifdef FIR_DECIM_SATCNT_EN
      ,.sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: enabled samples since reset/flush, queued samples, sticky flag, rail count.
   int q[$];
   int en_cnt;
   bit m_ovf;
   int m_sat;
   int m_last;
   int acc_log[$];

   task automatic check(input string name, input logic signed [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      en_cnt = 0;
      m_ovf  = 1'b0;
      m_sat  = 0;
      m_last = 0;
   endtask

   task automatic model_step();
      bit pop, keep;
      int y;
      y = int'(y_in);
      if (flush) begin
         q.delete();
         en_cnt = 0;
         m_ovf  = 1'b0;
         m_sat  = 0;
      end else begin
         pop  = (q.size() != 0) && out_ready;
         keep = 1'b0;
         if (enable) begin
            en_cnt++;
            keep = (en_cnt > L) && (((en_cnt - L - 1) % DECIM) == 0);
         end
         if (keep && (y == 32767 || y == -32768) && m_sat < 65535) m_sat++;
         if (keep && q.size() == DEPTH && !pop) m_ovf = 1'b1;
         if (pop) void'(q.pop_front());
         if (keep && q.size() < DEPTH) q.push_back(y);
      end
   endtask

   task automatic compare();
      int exp_data;
      exp_data = (q.size() != 0) ? q[0] : m_last;
      check("out_valid", out_valid, (q.size() != 0) ? 1 : 0);
      check("out_data", out_data, exp_data);
      check("fill_level", fill_level, q.size());
      check("warm", warm, (en_cnt >= L) ? 1 : 0);
      check("overflow", overflow, m_ovf ? 1 : 0);
`ifdef FIR_DECIM_SATCNT_EN
      check("sat_count", sat_count, m_sat);
`endif
      if (q.size() != 0) m_last = q[0];
   endtask

   // Called just after a falling edge: apply inputs, let one rising edge pass, compare.
   task automatic cycle(input logic en, input logic fl, input logic signed [15:0] y,
                        input logic rdy);
      if (out_valid && rdy && !fl) acc_log.push_back(int'(out_data));
      enable    = en;
      flush     = fl;
      y_in      = y;
      out_ready = rdy;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_fill", fill_level, 0);
      check("rst_warm", warm, 0);
      check("rst_ovf", overflow, 0);
`ifdef FIR_DECIM_SATCNT_EN
      check("rst_sat", sat_count, 0);
`endif
      model_reset();
      enable    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      compare();
   endtask

   task automatic ramp_run(input int n, input logic rdy);
      for (int k = 1; k <= n; k++) begin
         cycle(1'b1, 1'b0, 16'(k), rdy);
         if (k == L - 1) check("warm_before", warm, 0);
         if (k == L)     check("warm_after", warm, 1);
      end
   endtask

   task automatic check_log3(input string name);
      if (acc_log.size() < 3) begin
         check({name, "_count"}, acc_log.size(), 3);
      end else begin
         check({name, "_0"}, acc_log[0], 10);
         check({name, "_1"}, acc_log[1], 14);
         check({name, "_2"}, acc_log[2], 18);
      end
   endtask

   initial begin
      logic signed [15:0] yv;
      int rprob;
      int en_seen;
      model_reset();
      @(negedge clk);
      do_reset();

      // Streaming ramp with a ready consumer.
      acc_log.delete();
      ramp_run(30, 1'b1);
      check_log3("s1_out");
      check("s1_ovf", overflow, 0);

      // Stalled consumer: FIFO fills with the first 8 keeps, then overflows.
      do_reset();
      acc_log.delete();
      ramp_run(L + 40, 1'b0);
      check("s2_fill", fill_level, 8);
      check("s2_ovf", overflow, 1);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 16'sd0, 1'b1);
      check("s2_count", acc_log.size(), 8);
      for (int i = 0; i < acc_log.size() && i < 8; i++)
         check("s2_data", acc_log[i], 10 + 4 * i);

      // Full FIFO with push and pop on the same edge.
      do_reset();
      for (int k = 1; k <= 41; k++) cycle(1'b1, 1'b0, 16'(k), 1'b0);
      check("s3_full", fill_level, 8);
      cycle(1'b1, 1'b0, 16'sd42, 1'b1);
      check("s3_fill", fill_level, 8);
      check("s3_ovf", overflow, 0);
      check("s3_head", out_data, 14);
      cycle(1'b0, 1'b0, 16'sd0, 1'b0);

      // Gapped enable: decimation counts enabled cycles only.
      do_reset();
      acc_log.delete();
      en_seen = 0;
      for (int k = 0; k < 60; k++) begin
         if (k % 3 == 0) begin
            en_seen++;
            cycle(1'b1, 1'b0, 16'(en_seen), 1'b1);
         end else begin
            cycle(1'b0, 1'b0, 16'sd0, 1'b1);
         end
      end
      check_log3("s4_out");

      // Flush with 5 entries queued, then a full warm-up again.
      do_reset();
      for (int k = 1; k <= 26; k++) cycle(1'b1, 1'b0, 16'(k), 1'b0);
      check("s5_fill_pre", fill_level, 5);
      cycle(1'b1, 1'b1, 16'sd27, 1'b1);
      check("s5_fill", fill_level, 0);
      check("s5_valid", out_valid, 0);
      check("s5_warm", warm, 0);
      check("s5_ovf", overflow, 0);
      for (int k = 1; k <= L - 1; k++) cycle(1'b1, 1'b0, 16'(k), 1'b1);
      check("s5_warm8", warm, 0);
      cycle(1'b1, 1'b0, 16'sd9, 1'b1);
      check("s5_warm9", warm, 1);

      // Asynchronous reset mid-stream, then the streaming ramp again.
      for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 16'(100 + k), 1'b0);
      do_reset();
      acc_log.delete();
      ramp_run(30, 1'b1);
      check_log3("s6_out");

`ifdef FIR_DECIM_SATCNT_EN
      do_reset();
      for (int k = 1; k <= 18; k++) cycle(1'b1, 1'b0, 16'sd32767, 1'b1);
      check("s6_sat3", sat_count, 3);
`endif

      // Randomized traffic with varying consumer pressure.
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         rprob = $urandom_range(5, 95);
         if (blk == 8) do_reset();
         for (int k = 0; k < 100; k++) begin
            case ($urandom_range(0, 9))
               0:       yv = 16'sh7FFF;
               1:       yv = -16'sh8000;
               default: yv = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 99) < 75), ($urandom_range(0, 199) == 0), yv,
                  ($urandom_range(0, 99) < rprob));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
